// File: rtl/highway_controller.sv
// Highway-side traffic light controller for a highway/country-road crossing.
// Highway stays green until a country-road car waits and the interval timer
// expires, then runs yellow -> red (country go window) -> all-red clearance.
// Outputs are decoded from the next state and registered, so they change on
// the same edge as the state and have no combinational path from the inputs.
module highway_controller #(
  parameter int unsigned YELLOW_CYCLES  = 3,
  parameter int unsigned RED_MIN_CYCLES = 4,
  parameter int unsigned CLEAR_CYCLES   = 2,
  parameter int unsigned CNT_W          = 4
) (
  input  logic       clk,
  input  logic       rst_n,               // active-high synchronous reset
  input  logic       sensor,
  input  logic       timeout,
  output logic       enable_countryroad,
  output logic [2:0] highway_led
);

  localparam int unsigned LED_W = 3;

  localparam logic [CNT_W-1:0] YEL_LAST   = CNT_W'(YELLOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] RED_LAST   = CNT_W'(RED_MIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'(CLEAR_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  localparam logic [LED_W-1:0] LED_GREEN  = LED_W'(3'b001);
  localparam logic [LED_W-1:0] LED_YELLOW = LED_W'(3'b010);
  localparam logic [LED_W-1:0] LED_RED    = LED_W'(3'b100);

  typedef enum logic [1:0] {
    ST_GREEN     = 2'b00,
    ST_YELLOW    = 2'b01,
    ST_RED_GO    = 2'b10,
    ST_RED_CLEAR = 2'b11
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [LED_W-1:0]   led_q, led_d;
  logic               en_q, en_d;

  // State, phase counter and registered lamp outputs; reset wins over inputs.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q <= ST_GREEN;
      cnt_q   <= '0;
      led_q   <= LED_GREEN;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      led_q   <= led_d;
      en_q    <= en_d;
    end
  end

  // Next-state and phase-counter logic; inputs only matter in GREEN and RED_GO.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_GREEN: begin
        if (sensor && timeout) begin
          state_d = ST_YELLOW;
          cnt_d   = '0;
        end
      end
      ST_YELLOW: begin
        if (cnt_q == YEL_LAST) begin
          state_d = ST_RED_GO;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_RED_GO: begin
        // Counter saturates at the minimum window; the window then stretches
        // while cars still wait and the timer has not expired.
        if (cnt_q == RED_LAST) begin
          if (!sensor || timeout) begin
            state_d = ST_RED_CLEAR;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_RED_CLEAR: begin
        if (cnt_q == CLEAR_LAST) begin
          state_d = ST_GREEN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_GREEN;
        cnt_d   = '0;
      end
    endcase
  end

  // Moore output decode of the upcoming state, captured alongside it.
  always_comb begin
    led_d = LED_GREEN;
    en_d  = 1'b0;
    case (state_d)
      ST_GREEN:     led_d = LED_GREEN;
      ST_YELLOW:    led_d = LED_YELLOW;
      ST_RED_GO: begin
        led_d = LED_RED;
        en_d  = 1'b1;
      end
      ST_RED_CLEAR: led_d = LED_RED;
      default:      led_d = LED_GREEN;
    endcase
  end

  assign highway_led        = led_q;
  assign enable_countryroad = en_q;

endmodule

// File: tb/tb_highway_controller.sv
// Scoreboard bench for highway_controller: a default-parameter instance and a
// 1/1/1 instance share stimulus; a phase/duration model predicts lamps.
module tb_highway_controller;

  localparam int PH_GREEN = 0;
  localparam int PH_YEL   = 1;
  localparam int PH_GO    = 2;
  localparam int PH_CLR   = 3;

  typedef struct {
    logic [2:0] led_a;
    logic       en_a;
    logic [2:0] led_b;
    logic       en_b;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sensor;
  logic       timeout;
  logic       en_a, en_b;
  logic [2:0] led_a, led_b;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Model state: current phase and how many cycles it has been shown.
  int ph_a = PH_GREEN, t_a = 1;
  int ph_b = PH_GREEN, t_b = 1;

  always #5 clk = ~clk;

  highway_controller u_dflt (
    .clk(clk), .rst_n(rst_n), .sensor(sensor), .timeout(timeout),
    .enable_countryroad(en_a), .highway_led(led_a)
  );

  highway_controller #(
    .YELLOW_CYCLES(1), .RED_MIN_CYCLES(1), .CLEAR_CYCLES(1), .CNT_W(4)
  ) u_fast (
    .clk(clk), .rst_n(rst_n), .sensor(sensor), .timeout(timeout),
    .enable_countryroad(en_b), .highway_led(led_b)
  );

  // Phase rules: yellow lasts yc cycles, the go window at least rc cycles and
  // ends once the car is gone or the timer fired, clearance lasts cc cycles.
  task automatic model_step(inout int ph, inout int t, input bit r, input bit s,
                            input bit to, input int yc, input int rc, input int cc);
    if (r) begin
      ph = PH_GREEN; t = 1;
    end else begin
      case (ph)
        PH_GREEN: if (s && to) begin ph = PH_YEL;   t = 1; end else t++;
        PH_YEL:   if (t >= yc) begin ph = PH_GO;    t = 1; end else t++;
        PH_GO:    if (t >= rc && (!s || to)) begin ph = PH_CLR; t = 1; end else t++;
        default:  if (t >= cc) begin ph = PH_GREEN; t = 1; end else t++;
      endcase
    end
  endtask

  function automatic logic [2:0] lamp(input int ph);
    return (ph == PH_GREEN) ? 3'b001 : (ph == PH_YEL) ? 3'b010 : 3'b100;
  endfunction

  task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  // One clock of stimulus: drive, let the edge happen, predict, push expectation.
  task automatic cycle(input logic r, input logic s, input logic to);
    exp_t e;
    rst_n = r; sensor = s; timeout = to;
    @(posedge clk);
    model_step(ph_a, t_a, r === 1'b1, s === 1'b1, to === 1'b1, 3, 4, 2);
    model_step(ph_b, t_b, r === 1'b1, s === 1'b1, to === 1'b1, 1, 1, 1);
    e.led_a = lamp(ph_a); e.en_a = (ph_a == PH_GO);
    e.led_b = lamp(ph_b); e.en_b = (ph_b == PH_GO);
    exp_q.push_back(e);
    #1;
  endtask

  // Monitor: compare every presented output against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("dflt_led", led_a, e.led_a);
        check("dflt_en", {2'b00, en_a}, {2'b00, e.en_a});
        check("fast_led", led_b, e.led_b);
        check("fast_en", {2'b00, en_b}, {2'b00, e.en_b});
      end
    end
  end

  initial begin
    // Reset with undriven side inputs, then idle.
    repeat (2) cycle(1'b1, 1'bx, 1'bx);
    repeat (10) cycle(1'b0, 1'b0, 1'b0);
    // A waiting car alone, then a timeout alone: highway stays green.
    repeat (10) cycle(1'b0, 1'b1, 1'b0);
    repeat (10) cycle(1'b0, 1'b0, 1'b1);
    // Both held: continuous cycling.
    repeat (25) cycle(1'b0, 1'b1, 1'b1);
    // Extended go window while car waits and timer runs, then car leaves.
    repeat (2) cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b1);
    repeat (14) cycle(1'b0, 1'b1, 1'b0);
    repeat (5) cycle(1'b0, 1'b0, 1'b0);
    // Timeout dropping during yellow has no effect.
    cycle(1'b0, 1'b1, 1'b1);
    repeat (12) cycle(1'b0, 1'b0, 1'b0);
    // Reset pulse in yellow, then in the go window.
    repeat (2) cycle(1'b0, 1'b1, 1'b1);
    cycle(1'b1, 1'b1, 1'b1);
    repeat (6) cycle(1'b0, 1'b1, 1'b1);
    cycle(1'b1, 1'b1, 1'b1);
    repeat (4) cycle(1'b0, 1'b0, 1'b0);
    // Randomized traffic with occasional resets.
    for (int i = 0; i < 1500; i++) begin
      cycle(($urandom_range(0, 79) == 0) ? 1'b1 : 1'b0,
            ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
            ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0);
    end
    repeat (2) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/highway_controller.md
# highway_controller

Moore-style traffic-light controller for the highway side of a highway/country-road intersection. The highway light stays green until a vehicle is waiting on the country road and an external timer reports timeout. It then sequences highway yellow and red, and grants the country road a go window through `enable_countryroad`. The block sits beside a companion country-road light controller and an external interval timer, both of which consume `enable_countryroad`.

## Interface
Parameters:
- `YELLOW_CYCLES`, default 3: number of cycles the highway light shows yellow; legal range ≥1.
- `RED_MIN_CYCLES`, default 4: minimum number of cycles of the country-road go window; legal range ≥1.
- `CLEAR_CYCLES`, default 2: all-red clearance cycles after the go window, before highway green; legal range ≥1.
- `CNT_W`, default 4: phase-counter width. It must hold max(parameter) − 1.

Ports:
- `clk`, input, 1 bit: sole clock. All state changes on the rising edge.
- `rst_n`, input, 1 bit: reset. Synchronous and active-high; the port keeps the codebase name even though it is active-high. While `rst_n`=1 at a rising edge, the block is reset.
- `sensor`, input, 1 bit: 1 means a vehicle is waiting on the country road.
- `timeout`, input, 1 bit: 1 means the external interval timer has expired.
- `enable_countryroad`, output, 1 bit: 1 means the country road may go. High only in state RED_GO.
- `highway_led`, output, 3 bits: highway lamp, one-hot {red, yellow, green}. Green = 3'b001, yellow = 3'b010, red = 3'b100.

## Operation
States use a 2-bit encoding, plus a `CNT_W`-bit phase counter `cnt`.
- GREEN (00): `highway_led`=001, `enable_countryroad`=0. Go to YELLOW when `sensor` && `timeout`; `cnt` ← 0. Otherwise stay.
- YELLOW (01): `highway_led`=010, `enable_countryroad`=0. `cnt` increments each cycle. When `cnt`==`YELLOW_CYCLES`−1, go to RED_GO; `cnt` ← 0.
- RED_GO (10): `highway_led`=100, `enable_countryroad`=1. `cnt` increments and saturates at `RED_MIN_CYCLES`−1. Leave for RED_CLEAR when `cnt`==`RED_MIN_CYCLES`−1 and (!`sensor` || `timeout`); `cnt` ← 0. Otherwise stay, which extends the go window while cars wait and the timer is running.
- RED_CLEAR (11): `highway_led`=100, `enable_countryroad`=0. `cnt` increments. When `cnt`==`CLEAR_CYCLES`−1, go to GREEN; `cnt` ← 0.
- Inputs are ignored in YELLOW and RED_CLEAR.
- Inputs are ignored during reset. X or undriven inputs while reset is asserted must not affect state.
- An illegal or unreachable state encoding recovers to GREEN on the next edge, with `cnt` ← 0.
- `sensor` and `timeout` are assumed synchronous to `clk`. No internal synchronizers.

## Timing
- Outputs are decoded from the state register only (Moore). They change on the same edge as the state, with no combinational path from inputs to outputs.
- Reset: on any edge with `rst_n`=1, state ← GREEN and `cnt` ← 0. Outputs are then `highway_led`=001 and `enable_countryroad`=0.
- Reset asserted mid-sequence (any state) aborts the sequence to GREEN at that edge.
- Latency, with defaults:
  - `sensor`&`timeout` sampled high in GREEN at edge N → yellow visible from N through N+3.
  - RED_GO from edge N+3.
  - Earliest RED_CLEAR at N+7.
  - GREEN at N+9.
- Total yellow display = `YELLOW_CYCLES` cycles; minimum go window = `RED_MIN_CYCLES` cycles; clearance = `CLEAR_CYCLES` cycles.
- `sensor` and `timeout` both held at 1 forever: the block cycles continuously, GREEN 1 cycle → YELLOW 3 → RED_GO 4 → RED_CLEAR 2 → GREEN.
- `timeout` dropping during YELLOW or RED_CLEAR has no effect.

## Test plan
- Reset held for 2 cycles with `sensor`=`timeout`=0, then released for 10 cycles → `highway_led`=001 and `enable_countryroad`=0 throughout.
- After reset, `sensor`=1 with `timeout`=0 for 10 cycles → remains GREEN (001). `timeout` alone (`sensor`=0) → remains GREEN.
- `sensor`=`timeout`=1 from GREEN → `highway_led`=010 for exactly 3 cycles, then 100 with `enable_countryroad`=1 for 4 cycles, then 100 with enable=0 for 2 cycles, then 001. The sequence then repeats while both inputs stay 1.
- In RED_GO, `sensor`=1 and `timeout`=0 held → `enable_countryroad` stays 1 beyond 4 cycles. Dropping `sensor` → RED_CLEAR on the next edge.
- `rst_n`=1 for one cycle while in YELLOW or RED_GO → on that edge `highway_led`=001, `enable_countryroad`=0, and the sequence restarts from GREEN.
- Override parameters `YELLOW_CYCLES`=1, `RED_MIN_CYCLES`=1, `CLEAR_CYCLES`=1 → each phase lasts exactly 1 cycle with inputs held at 1.
